mem_arbiter: RTL and testbench

- Sequences the shared 32x8 synchronous data memory (signals rd, wrt, mux_addr, bidirectional data_bus) and shares it between two requesters: A (fetch side) and B (execute/load-store side).
- Converts per-requester req/ack handshakes into correctly timed memory rd/wrt cycles, drives data_bus only during writes, and captures read data.
- Sits between the CPU control/datapath and the memory block; it is the only driver of the memory control pins.

---
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes plus memory control pins of mem_arbiter.
// The bidirectional data_bus stays a plain inout port on the arbiter.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
);
    logic              req_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a;
    logic              ack_a;

    logic              req_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic              ack_b;

    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              mem_rd;
    logic              mem_wrt;
    logic [ADDR_W-1:0] mem_addr;

    // Requester / environment side
    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        input  ack_a, ack_b, rdata, busy, mem_rd, mem_wrt, mem_addr
    );

    // Arbiter side
    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        output ack_a, ack_b, rdata, busy, mem_rd, mem_wrt, mem_addr
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a 32x8 synchronous memory between requesters A and B and
// sequences the rd/wrt/addr/data_bus cycles. All outputs are registered.
// Optional macro ARB_FIXED_PRIO_EN: A always wins a tie (default is round-robin).
module mem_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_if.slave      bus,
    inout  wire  [DATA_W-1:0] data_bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner_q;     // granted requester, 1 = B
    logic              owner_nxt;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] rdata_nxt;
    logic              mem_rd_nxt;
    logic              mem_wrt_nxt;
    logic              busy_nxt;
    logic              ack_a_nxt;
    logic              ack_b_nxt;
    logic              elig_a;
    logic              elig_b;
    logic              pick_b;
    logic              done;
`ifndef ARB_FIXED_PRIO_EN
    logic              last_b;      // last grant went to B
    logic              last_b_nxt;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration, next state and next registered outputs
    always_comb begin
        state_nxt = state;
        owner_nxt = owner_q;
        wdata_nxt = wdata_q;
        addr_nxt  = bus.mem_addr;
        rdata_nxt = bus.rdata;
        pick_b    = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
        last_b_nxt = last_b;
`endif
        // A request is ignored in the cycle its own ack is shown
        elig_a = bus.req_a && !bus.ack_a;
        elig_b = bus.req_b && !bus.ack_b;
        done   = (state == RD2) || (state == WR);

        case (state)
            IDLE: begin
`ifdef ARB_FIXED_PRIO_EN
                pick_b = elig_b && !elig_a;
`else
                pick_b = elig_b && (!elig_a || !last_b);
`endif
                if (elig_a || elig_b) begin
                    owner_nxt = pick_b;
`ifndef ARB_FIXED_PRIO_EN
                    last_b_nxt = pick_b;
`endif
                    addr_nxt  = pick_b ? bus.addr_b  : bus.addr_a;
                    wdata_nxt = pick_b ? bus.wdata_b : bus.wdata_a;
                    state_nxt = (pick_b ? bus.we_b : bus.we_a) ? WR : RD1;
                end
            end
            RD1: state_nxt = RD2;
            RD2: begin
                state_nxt = IDLE;
                rdata_nxt = data_bus;
            end
            WR:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        mem_rd_nxt  = (state_nxt == RD1) || (state_nxt == RD2);
        mem_wrt_nxt = (state_nxt == WR);
        busy_nxt    = (state_nxt != IDLE);
        ack_a_nxt   = done && !owner_q;
        ack_b_nxt   = done && owner_q;
    end

    // Registered outputs and latched transaction fields
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q      <= 1'b0;
            wdata_q      <= '0;
            bus.mem_rd   <= 1'b0;
            bus.mem_wrt  <= 1'b0;
            bus.mem_addr <= '0;
            bus.busy     <= 1'b0;
            bus.ack_a    <= 1'b0;
            bus.ack_b    <= 1'b0;
            bus.rdata    <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_b       <= 1'b1;
`endif
        end else begin
            owner_q      <= owner_nxt;
            wdata_q      <= wdata_nxt;
            bus.mem_rd   <= mem_rd_nxt;
            bus.mem_wrt  <= mem_wrt_nxt;
            bus.mem_addr <= addr_nxt;
            bus.busy     <= busy_nxt;
            bus.ack_a    <= ack_a_nxt;
            bus.ack_b    <= ack_b_nxt;
            bus.rdata    <= rdata_nxt;
`ifndef ARB_FIXED_PRIO_EN
            last_b       <= last_b_nxt;
`endif
        end
    end

    // Bus is driven only while the write cycle is active
    assign data_bus = (state == WR) ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a 32x8
// synchronous memory model and a reference memory array.
module tb_mem_arbiter;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 8;

    logic clk = 1'b0;
    logic rst;
    wire [DATA_W-1:0] data_bus;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (ifc.slave),
        .data_bus (data_bus)
    );

    always #5 clk = ~clk;

    logic [7:0] phys_mem [32];
    logic [7:0] ref_mem  [32];
    logic [7:0] mem_q;
    logic       rd_q;
    logic       probe_en;
    logic [7:0] probe_val;
    int         n_checks;
    int         n_fail;

    // Synchronous memory: registers the word during the first rd cycle, drives it in the second
    always @(posedge clk) begin
        rd_q <= ifc.mem_rd;
        if (ifc.mem_rd) mem_q <= phys_mem[ifc.mem_addr];
        if (ifc.mem_wrt) phys_mem[ifc.mem_addr] <= data_bus;
    end

    assign data_bus = (ifc.mem_rd && rd_q) ? mem_q : (probe_en ? probe_val : 8'hzz);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one or two requests, drop each on its ack, report ack cycle and rdata
    task automatic run_pair(input bit en_a, input bit a_we, input logic [4:0] a_addr, input logic [7:0] a_wd,
                            input bit en_b, input bit b_we, input logic [4:0] b_addr, input logic [7:0] b_wd,
                            output int a_cyc, output int b_cyc, output logic [7:0] a_rd, output logic [7:0] b_rd);
        a_cyc = en_a ? -1 : 0;
        b_cyc = en_b ? -1 : 0;
        a_rd = 8'h00;
        b_rd = 8'h00;
        ifc.req_a = en_a; ifc.we_a = a_we; ifc.addr_a = a_addr; ifc.wdata_a = a_wd;
        ifc.req_b = en_b; ifc.we_b = b_we; ifc.addr_b = b_addr; ifc.wdata_b = b_wd;
        for (int c = 1; c <= 20 && (a_cyc < 0 || b_cyc < 0); c++) begin
            cyc();
            if (ifc.ack_a && a_cyc < 0) begin a_cyc = c; a_rd = ifc.rdata; ifc.req_a = 1'b0; end
            if (ifc.ack_b && b_cyc < 0) begin b_cyc = c; b_rd = ifc.rdata; ifc.req_b = 1'b0; end
        end
        ifc.req_a = 1'b0;
        ifc.req_b = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ifc.req_a = 1'b1; ifc.we_a = 1'b0; ifc.addr_a = 5'd3;
        probe_en = 1'b1; probe_val = 8'h5A;
        for (int k = 0; k < 2; k++) begin
            cyc();
            n_checks++;
            if (ifc.busy !== 1'b0 || ifc.mem_rd !== 1'b0 || ifc.mem_wrt !== 1'b0 || ifc.ack_a !== 1'b0 || ifc.ack_b !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ctrl cyc%0d: busy=%b rd=%b wrt=%b ack_a=%b ack_b=%b, required all 0",
                         k, ifc.busy, ifc.mem_rd, ifc.mem_wrt, ifc.ack_a, ifc.ack_b);
            end
            n_checks++;
            if (ifc.mem_addr !== 5'd0 || ifc.rdata !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_vals cyc%0d: mem_addr=%0d rdata=%h, required 0/00", k, ifc.mem_addr, ifc.rdata);
            end
            n_checks++;
            if (data_bus !== 8'h5A) begin
                n_fail++;
                $display("FAIL reset_bus_hiz: data_bus=%h, required probe 5a", data_bus);
            end
        end
        probe_en = 1'b0;
        rst = 1'b1;
        cyc();
        n_checks++;
        if (ifc.mem_rd !== 1'b1 || ifc.mem_wrt !== 1'b0 || ifc.mem_addr !== 5'd3 || ifc.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_grant_rd1: rd=%b wrt=%b addr=%0d busy=%b, required 1/0/3/1",
                     ifc.mem_rd, ifc.mem_wrt, ifc.mem_addr, ifc.busy);
        end
        cyc();
        n_checks++;
        if (ifc.mem_rd !== 1'b1 || ifc.ack_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rd2: rd=%b ack_a=%b, required 1/0", ifc.mem_rd, ifc.ack_a);
        end
        cyc();
        n_checks++;
        if (ifc.ack_a !== 1'b1 || ifc.rdata !== 8'h25 || ifc.mem_rd !== 1'b0 || ifc.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_read: ack_a=%b rdata=%h rd=%b busy=%b, required 1/25/0/0",
                     ifc.ack_a, ifc.rdata, ifc.mem_rd, ifc.busy);
        end
        ifc.req_a = 1'b0;
        cyc();
        n_checks++;
        if (ifc.ack_a !== 1'b0 || ifc.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ack_pulse: ack_a=%b busy=%b, required 0/0", ifc.ack_a, ifc.busy);
        end
    endtask

    task automatic test_write_read();
        ifc.req_b = 1'b1; ifc.we_b = 1'b1; ifc.addr_b = 5'd7; ifc.wdata_b = 8'hA5;
        cyc();
        n_checks++;
        if (ifc.mem_wrt !== 1'b1 || ifc.mem_rd !== 1'b0 || ifc.mem_addr !== 5'd7 || data_bus !== 8'hA5 || ifc.ack_b !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_cycle: wrt=%b rd=%b addr=%0d bus=%h ack_b=%b, required 1/0/7/a5/0",
                     ifc.mem_wrt, ifc.mem_rd, ifc.mem_addr, data_bus, ifc.ack_b);
        end
        cyc();
        probe_en = 1'b1; probe_val = 8'h5A;
        #1;
        n_checks++;
        if (ifc.ack_b !== 1'b1 || ifc.mem_wrt !== 1'b0 || data_bus !== 8'h5A) begin
            n_fail++;
            $display("FAIL wr_ack: ack_b=%b wrt=%b bus=%h, required 1/0/5a", ifc.ack_b, ifc.mem_wrt, data_bus);
        end
        probe_en = 1'b0;
        ref_mem[7] = 8'hA5;
        ifc.req_b = 1'b0;
        cyc();
        ifc.req_b = 1'b1; ifc.we_b = 1'b0; ifc.addr_b = 5'd7;
        cyc();
        n_checks++;
        if (ifc.mem_rd !== 1'b1 || ifc.mem_wrt !== 1'b0 || ifc.mem_addr !== 5'd7) begin
            n_fail++;
            $display("FAIL rd1_cycle: rd=%b wrt=%b addr=%0d, required 1/0/7", ifc.mem_rd, ifc.mem_wrt, ifc.mem_addr);
        end
        cyc();
        n_checks++;
        if (ifc.mem_rd !== 1'b1 || ifc.ack_b !== 1'b0) begin
            n_fail++;
            $display("FAIL rd2_cycle: rd=%b ack_b=%b, required 1/0", ifc.mem_rd, ifc.ack_b);
        end
        cyc();
        n_checks++;
        if (ifc.ack_b !== 1'b1 || ifc.rdata !== 8'hA5 || ifc.mem_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_ack: ack_b=%b rdata=%h rd=%b, required 1/a5/0", ifc.ack_b, ifc.rdata, ifc.mem_rd);
        end
        ifc.req_b = 1'b0;
        cyc();
    endtask

    task automatic test_simultaneous();
        int ac, bc;
        logic [7:0] ard, brd;
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        run_pair(1'b1, 1'b0, 5'd3, 8'h00, 1'b1, 1'b1, 5'd3, 8'h3C, ac, bc, ard, brd);
        n_checks++;
        if (ac != 3 || ard !== 8'h25 || bc != 5) begin
            n_fail++;
            $display("FAIL tie_after_reset: ack_a@%0d rdata=%h ack_b@%0d, required 3/25/5", ac, ard, bc);
        end
        ref_mem[3] = 8'h3C;
        run_pair(1'b1, 1'b1, 5'd9, 8'h99, 1'b0, 1'b0, 5'd0, 8'h00, ac, bc, ard, brd);
        n_checks++;
        if (ac != 2) begin
            n_fail++;
            $display("FAIL solo_write_a: ack_a@%0d, required 2", ac);
        end
        ref_mem[9] = 8'h99;
        run_pair(1'b1, 1'b0, 5'd3, 8'h00, 1'b1, 1'b1, 5'd3, 8'hC3, ac, bc, ard, brd);
        n_checks++;
`ifdef ARB_FIXED_PRIO_EN
        if (ac != 3 || ard !== 8'h3C || bc != 5) begin
            n_fail++;
            $display("FAIL tie_fixed_prio: ack_a@%0d rdata=%h ack_b@%0d, required 3/3c/5", ac, ard, bc);
        end
`else
        if (bc != 2 || ac != 5 || ard !== 8'hC3) begin
            n_fail++;
            $display("FAIL tie_round_robin: ack_b@%0d ack_a@%0d rdata=%h, required 2/5/c3", bc, ac, ard);
        end
`endif
        ref_mem[3] = 8'hC3;
    endtask

    task automatic test_back_to_back();
        ifc.req_a = 1'b1; ifc.we_a = 1'b0; ifc.addr_a = 5'd7;
        cyc(); cyc(); cyc();
        n_checks++;
        if (ifc.ack_a !== 1'b1 || ifc.rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL b2b_first: ack_a=%b rdata=%h, required 1/a5", ifc.ack_a, ifc.rdata);
        end
        ifc.addr_a = 5'd9;
        cyc();
        n_checks++;
        if (ifc.busy !== 1'b0 || ifc.mem_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ignored: busy=%b rd=%b, required 0/0", ifc.busy, ifc.mem_rd);
        end
        cyc();
        n_checks++;
        if (ifc.mem_rd !== 1'b1 || ifc.mem_addr !== 5'd9) begin
            n_fail++;
            $display("FAIL b2b_regrant: rd=%b addr=%0d, required 1/9", ifc.mem_rd, ifc.mem_addr);
        end
        cyc(); cyc();
        n_checks++;
        if (ifc.ack_a !== 1'b1 || ifc.rdata !== 8'h99) begin
            n_fail++;
            $display("FAIL b2b_second: ack_a=%b rdata=%h, required 1/99", ifc.ack_a, ifc.rdata);
        end
        ifc.req_a = 1'b0;
        cyc();
        // Second round with B pending when A's ack shows
        ifc.req_a = 1'b1; ifc.addr_a = 5'd7;
        cyc();
        ifc.req_b = 1'b1; ifc.we_b = 1'b1; ifc.addr_b = 5'd12; ifc.wdata_b = 8'h12;
        cyc(); cyc();
        n_checks++;
        if (ifc.ack_a !== 1'b1 || ifc.rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL b2b_pend_first: ack_a=%b rdata=%h, required 1/a5", ifc.ack_a, ifc.rdata);
        end
        ifc.addr_a = 5'd9;
        cyc();
        n_checks++;
        if (ifc.mem_wrt !== 1'b1 || ifc.mem_addr !== 5'd12 || data_bus !== 8'h12 || ifc.ack_a !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_b_granted: wrt=%b addr=%0d bus=%h ack_a=%b, required 1/12/12/0",
                     ifc.mem_wrt, ifc.mem_addr, data_bus, ifc.ack_a);
        end
        cyc();
        n_checks++;
        if (ifc.ack_b !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ack_b: ack_b=%b, required 1", ifc.ack_b);
        end
        ifc.req_b = 1'b0;
        ref_mem[12] = 8'h12;
        cyc();
        n_checks++;
        if (ifc.mem_rd !== 1'b1 || ifc.mem_addr !== 5'd9) begin
            n_fail++;
            $display("FAIL b2b_a_after_b: rd=%b addr=%0d, required 1/9", ifc.mem_rd, ifc.mem_addr);
        end
        cyc(); cyc();
        n_checks++;
        if (ifc.ack_a !== 1'b1 || ifc.rdata !== 8'h99) begin
            n_fail++;
            $display("FAIL b2b_a_done: ack_a=%b rdata=%h, required 1/99", ifc.ack_a, ifc.rdata);
        end
        ifc.req_a = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_read();
        ifc.req_a = 1'b1; ifc.we_a = 1'b0; ifc.addr_a = 5'd3;
        cyc(); cyc();
        n_checks++;
        if (ifc.mem_rd !== 1'b1 || ifc.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midrd_in_rd2: rd=%b busy=%b, required 1/1", ifc.mem_rd, ifc.busy);
        end
        rst = 1'b0;
        ifc.req_a = 1'b0;
        cyc();
        probe_en = 1'b1; probe_val = 8'h5A;
        #1;
        n_checks++;
        if (ifc.ack_a !== 1'b0 || ifc.busy !== 1'b0 || ifc.mem_rd !== 1'b0 || ifc.rdata !== 8'h00 || data_bus !== 8'h5A) begin
            n_fail++;
            $display("FAIL midrd_abort: ack_a=%b busy=%b rd=%b rdata=%h bus=%h, required 0/0/0/00/5a",
                     ifc.ack_a, ifc.busy, ifc.mem_rd, ifc.rdata, data_bus);
        end
        probe_en = 1'b0;
        rst = 1'b1;
        cyc();
        n_checks++;
        if (ifc.ack_a !== 1'b0 || ifc.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrd_no_late_ack: ack_a=%b busy=%b, required 0/0", ifc.ack_a, ifc.busy);
        end
    endtask

    task automatic test_random();
        int issued = 0;
        int done = 0;
        int wait_a = 0;
        int wait_b = 0;
        ifc.req_a = 1'b0;
        ifc.req_b = 1'b0;
        for (int c = 0; c < 4000 && done < 200; c++) begin
            if (ifc.req_a && ifc.ack_a) begin
                done++;
                if (!ifc.we_a) begin
                    n_checks++;
                    if (ifc.rdata !== ref_mem[ifc.addr_a]) begin
                        n_fail++;
                        $display("FAIL rand_read_a addr=%0d: rdata=%h, required %h", ifc.addr_a, ifc.rdata, ref_mem[ifc.addr_a]);
                    end
                end else begin
                    ref_mem[ifc.addr_a] = ifc.wdata_a;
                end
                n_checks++;
                if (wait_a > 7) begin
                    n_fail++;
                    $display("FAIL rand_fair_a: waited %0d cycles, required <= 7", wait_a);
                end
                ifc.req_a = 1'b0;
            end
            if (ifc.req_b && ifc.ack_b) begin
                done++;
                if (!ifc.we_b) begin
                    n_checks++;
                    if (ifc.rdata !== ref_mem[ifc.addr_b]) begin
                        n_fail++;
                        $display("FAIL rand_read_b addr=%0d: rdata=%h, required %h", ifc.addr_b, ifc.rdata, ref_mem[ifc.addr_b]);
                    end
                end else begin
                    ref_mem[ifc.addr_b] = ifc.wdata_b;
                end
                n_checks++;
                if (wait_b > 7) begin
                    n_fail++;
                    $display("FAIL rand_fair_b: waited %0d cycles, required <= 7", wait_b);
                end
                ifc.req_b = 1'b0;
            end
            if (!ifc.req_a && issued < 200 && $urandom_range(1, 0) == 1) begin
                ifc.we_a = 1'($urandom_range(1, 0));
                ifc.addr_a = 5'($urandom_range(31, 0));
                ifc.wdata_a = 8'($urandom);
                ifc.req_a = 1'b1;
                issued++;
                wait_a = 0;
            end
            if (!ifc.req_b && issued < 200 && $urandom_range(1, 0) == 1) begin
                ifc.we_b = 1'($urandom_range(1, 0));
                ifc.addr_b = 5'($urandom_range(31, 0));
                ifc.wdata_b = 8'($urandom);
                ifc.req_b = 1'b1;
                issued++;
                wait_b = 0;
            end
            cyc();
            if (ifc.req_a) wait_a++;
            if (ifc.req_b) wait_b++;
            n_checks++;
            if (ifc.mem_rd && ifc.mem_wrt) begin
                n_fail++;
                $display("FAIL rand_rd_wrt_both: rd=%b wrt=%b, required not both 1", ifc.mem_rd, ifc.mem_wrt);
            end
            if (ifc.mem_rd && rd_q) begin
                n_checks++;
                if ($isunknown(data_bus)) begin
                    n_fail++;
                    $display("FAIL rand_bus_x: data_bus=%h during read, required known", data_bus);
                end
            end
            if (wait_a > 30 || wait_b > 30) begin
                n_checks++;
                n_fail++;
                $display("FAIL rand_timeout: wait_a=%0d wait_b=%0d, required ack within 30", wait_a, wait_b);
                break;
            end
        end
        n_checks++;
        if (done != 200) begin
            n_fail++;
            $display("FAIL rand_completed: %0d accesses acked, required 200", done);
        end
        ifc.req_a = 1'b0;
        ifc.req_b = 1'b0;
        cyc();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b0;
        probe_en = 1'b0;
        probe_val = 8'h00;
        ifc.req_a = 1'b0; ifc.we_a = 1'b0; ifc.addr_a = '0; ifc.wdata_a = '0;
        ifc.req_b = 1'b0; ifc.we_b = 1'b0; ifc.addr_b = '0; ifc.wdata_b = '0;
        for (int i = 0; i < 32; i++) begin
            phys_mem[i] = 8'(i * 7 + 16);
            ref_mem[i]  = 8'(i * 7 + 16);
        end
        test_reset();
        test_write_read();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
